// File: rtl/ita_package.sv
// Shared ITA types and constants for the activation output path.
// N lanes of WO-bit requantised outputs form one vector (requant_oup_t).
// ACT_LAT is the activation pipeline latency, shared with the activation unit.
// OUT_FIFO_DEPTH sizes the output buffer FIFO; OUT_CNT_W sizes the tile-length and beat-counter fields.
package ita_package;

  localparam int unsigned N              = 4;
  localparam int unsigned WO             = 8;
  localparam int unsigned ACT_LAT        = 2;
  localparam int unsigned OUT_FIFO_DEPTH = 4;
  localparam int unsigned OUT_CNT_W      = 16;

  typedef logic [N-1:0][WO-1:0] requant_oup_t;

endpackage

// File: rtl/ita_act_fifo.sv
// DEPTH-entry circular buffer of requant_oup_t vectors.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        synchronous flush, wins over push/pop
//   push_i/data_i  write data_i at the tail
//   pop_i          drop the head entry (caller guarantees not empty)
//   head_o         current head entry
//   cnt_o          number of stored entries
//   full_o/empty_o occupancy flags
module ita_act_fifo
  import ita_package::*;
#(
  parameter int unsigned DEPTH = OUT_FIFO_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           push_i,
  input  requant_oup_t   data_i,
  input  logic           pop_i,
  output requant_oup_t   head_o,
  output logic [CW-1:0]  cnt_o,
  output logic           full_o,
  output logic           empty_o
);

  requant_oup_t      r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [CW-1:0]     r_cnt;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push_i) r_wr <= wrap_inc(r_wr);
      if (pop_i)  r_rd <= wrap_inc(r_rd);
      case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage; at full, a push with a pop overwrites the slot being read out this cycle
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[r_wr] <= data_i;
  end

  assign head_o  = r_mem[r_rd];
  assign cnt_o   = r_cnt;
  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/ita_act_output_buffer.sv
// Output stage behind the fixed-latency activation unit.
// Tracks valid vectors through the activation pipeline, captures results into a
// FIFO and streams them out on valid/ready with a per-tile last flag. Upstream
// ready is credit based, so the stall-free activation pipeline never loses data.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   clear_i            synchronous flush of in-flight, stored and counted state
//   valid_i / ready_o  upstream issue handshake into the activation unit
//   act_data_i         activation result for the vector issued ACT_LAT cycles earlier
//   tile_len_i         vectors per tile (0 treated as 1), stable while busy_o
//   valid_o / ready_i  downstream stream handshake
//   data_o, last_o     output vector ('0 when idle) and end-of-tile flag
//   busy_o             something is in flight or stored
module ita_act_output_buffer
  import ita_package::*;
#(
  parameter int unsigned DEPTH   = OUT_FIFO_DEPTH,
  parameter int unsigned ACT_LAT = ita_package::ACT_LAT,
  parameter int unsigned CNT_W   = OUT_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  requant_oup_t      act_data_i,
  input  logic [CNT_W-1:0]  tile_len_i,
  output logic              valid_o,
  input  logic              ready_i,
  output requant_oup_t      data_o,
  output logic              last_o,
  output logic              busy_o
);

  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W  = $clog2(ACT_LAT + 1);
  localparam int unsigned SUM_W  = ((FCNT_W > INF_W) ? FCNT_W : INF_W) + 1;

  logic [ACT_LAT-1:0] r_vpipe;
  logic [ACT_LAT-1:0] w_vpipe_nxt;
  logic [CNT_W-1:0]   r_beat;
  logic [CNT_W-1:0]   w_tile_last;
  logic [INF_W-1:0]   w_inflight;
  logic [FCNT_W-1:0]  w_fifo_cnt;
  logic               w_credit;
  logic               w_acc;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  requant_oup_t       w_head;

  // Credit: every in-flight vector already owns a FIFO slot
  assign w_inflight = INF_W'($countones(r_vpipe));
  assign w_credit   = (SUM_W'(w_fifo_cnt) + SUM_W'(w_inflight)) < SUM_W'(DEPTH);
  assign ready_o    = w_credit & ~clear_i;
  assign w_acc      = valid_i & ready_o;

  // Valid pipe mirrors the activation latency; last stage marks act_data_i as real
  if (ACT_LAT == 1) begin : g_pipe1
    assign w_vpipe_nxt = w_acc;
  end else begin : g_pipen
    assign w_vpipe_nxt = {r_vpipe[ACT_LAT-2:0], w_acc};
  end
  assign w_push = r_vpipe[ACT_LAT-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vpipe <= '0;
    end else if (clear_i) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe <= w_vpipe_nxt;
    end
  end

  ita_act_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (w_push),
    .data_i  (act_data_i),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .cnt_o   (w_fifo_cnt),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign valid_o = ~w_fifo_empty;
  assign w_pop   = valid_o & ready_i;
  assign data_o  = valid_o ? w_head : '0;
  assign busy_o  = (w_inflight != '0) | ~w_fifo_empty;

  // Beat counter; tile_len_i of 0 behaves as 1
  assign w_tile_last = (tile_len_i == '0) ? '0 : tile_len_i - 1'b1;
  assign last_o      = valid_o & (r_beat == w_tile_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat <= '0;
    end else if (clear_i) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= last_o ? '0 : r_beat + 1'b1;
    end
  end

  // Credit reservation must keep the FIFO from overflowing
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    w_push |-> (!w_fifo_full || w_pop));

endmodule
